// File: rtl/tournament_branch_predictor_pkg.sv
// Shared types and helpers for the tournament branch predictor: FSM states,
// saturating counter arithmetic and init-sweep sizing.
package tournament_branch_predictor_pkg;

   // Widest counter the helper functions handle; callers cast down to CTR_WIDTH.
   localparam int CTR_MAX_W = 16;

   // Sweep length for the default 8/8/8 table configuration.
   localparam int DEF_SWEEP_LEN = 256;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bp_state_e;

   typedef logic [CTR_MAX_W-1:0] ctr_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Weakly-not-taken value: MSB clear, every lower bit set.
   function automatic ctr_t wnt_init(input int w);
      return CTR_MAX_W'((1 << (w - 1)) - 1);
   endfunction

   function automatic ctr_t sat_inc(input ctr_t v, input int w);
      return (v >= CTR_MAX_W'((1 << w) - 1)) ? v : v + CTR_MAX_W'(1);
   endfunction

   function automatic ctr_t sat_dec(input ctr_t v, input int w);
      return (v == '0) ? v : v - CTR_MAX_W'(1);
   endfunction

endpackage

// File: rtl/tournament_branch_predictor_if.sv
// Fetch-side prediction request/response plus commit-side training bus.
interface tournament_branch_predictor_if #(parameter int GHR_WIDTH = 8);
   logic                 ready;
   logic                 pred_valid;
   logic [31:0]          pred_pc;
   logic                 pred_taken;
   logic                 pred_local_taken;
   logic                 pred_global_taken;
   logic [GHR_WIDTH-1:0] pred_ghr;
   logic                 upd_valid;
   logic [31:0]          upd_pc;
   logic [GHR_WIDTH-1:0] upd_ghr;
   logic                 upd_taken;
   logic                 upd_local_taken;
   logic                 upd_global_taken;
   logic                 upd_mispredict;

   modport master (
      input  ready, pred_taken, pred_local_taken, pred_global_taken, pred_ghr,
      output pred_valid, pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken,
             upd_local_taken, upd_global_taken, upd_mispredict
   );

   modport slave (
      output ready, pred_taken, pred_local_taken, pred_global_taken, pred_ghr,
      input  pred_valid, pred_pc, upd_valid, upd_pc, upd_ghr, upd_taken,
             upd_local_taken, upd_global_taken, upd_mispredict
   );
endinterface

// File: rtl/tournament_branch_predictor_sat_counter_table.sv
// 2^IDX saturating counters: combinational read, one saturating update per
// cycle, and an init write port that takes priority during the reset sweep.
module sat_counter_table
   import tournament_branch_predictor_pkg::*;
#(
   parameter int IDX       = 8,
   parameter int CTR_WIDTH = 2
) (
   input  logic                 clk,
   input  logic [IDX-1:0]       rd_idx,
   output logic [CTR_WIDTH-1:0] rd_ctr,
   input  logic                 upd_en,
   input  logic [IDX-1:0]       upd_idx,
   input  logic                 upd_inc,
   input  logic                 init_en,
   input  logic [IDX-1:0]       init_idx
);

   logic [CTR_WIDTH-1:0] mem [0:(1<<IDX)-1];
   logic [CTR_WIDTH-1:0] cur;
   logic [CTR_WIDTH-1:0] nxt;

   assign rd_ctr = mem[rd_idx];
   assign cur    = mem[upd_idx];

   // Next value of the entry being trained, clamped at both ends.
   always_comb begin
      nxt = cur;
      if (upd_inc) nxt = CTR_WIDTH'(sat_inc(CTR_MAX_W'(cur), CTR_WIDTH));
      else         nxt = CTR_WIDTH'(sat_dec(CTR_MAX_W'(cur), CTR_WIDTH));
   end

   // Array storage has no reset; the init sweep establishes known contents.
   always_ff @(posedge clk) begin
      if (init_en)     mem[init_idx] <= CTR_WIDTH'(wnt_init(CTR_WIDTH));
      else if (upd_en) mem[upd_idx]  <= nxt;
   end

endmodule

// File: rtl/tournament_branch_predictor.sv
// Tournament predictor: local + gshare tables arbitrated by a PC-indexed
// chooser. Owns the init sweep FSM and the speculative global history.
module tournament_branch_predictor
   import tournament_branch_predictor_pkg::*;
#(
   parameter int CTR_WIDTH   = 2,
   parameter int LOCAL_IDX   = 8,
   parameter int GHR_WIDTH   = 8,
   parameter int CHOOSER_IDX = 8
) (
   input  logic clk,
   input  logic rst,
   tournament_branch_predictor_if.slave bp
);

   localparam int SWEEP_W = max3(LOCAL_IDX, GHR_WIDTH, CHOOSER_IDX);

   bp_state_e            state, state_n;
   logic [SWEEP_W-1:0]   init_idx;
   logic [GHR_WIDTH-1:0] ghr;
   logic                 run;
   logic [CTR_WIDTH-1:0] loc_ctr, glb_ctr, ch_ctr;
   logic                 loc_msb, glb_msb, ch_msb;

   assign run = (state == ST_RUN);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_INIT;
      else      state <= state_n;
   end

   // Leave the sweep once the last index has been written.
   always_comb begin
      state_n = state;
      case (state)
         ST_INIT: if (&init_idx) state_n = ST_RUN;
         ST_RUN:  state_n = ST_RUN;
         default: state_n = ST_INIT;
      endcase
   end

   // Sweep index walks every entry of the largest table once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     init_idx <= '0;
      else if (!run) init_idx <= init_idx + SWEEP_W'(1);
   end

   // Speculative history: commit-time repair beats the fetch-time shift.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr <= '0;
      end else if (run) begin
         if (bp.upd_valid && bp.upd_mispredict)
            ghr <= {bp.upd_ghr[GHR_WIDTH-2:0], bp.upd_taken};
         else if (bp.pred_valid)
            ghr <= {ghr[GHR_WIDTH-2:0], bp.pred_taken};
      end
   end

   sat_counter_table #(.IDX(LOCAL_IDX), .CTR_WIDTH(CTR_WIDTH)) u_local (
      .clk      (clk),
      .rd_idx   (bp.pred_pc[LOCAL_IDX+1:2]),
      .rd_ctr   (loc_ctr),
      .upd_en   (run && bp.upd_valid),
      .upd_idx  (bp.upd_pc[LOCAL_IDX+1:2]),
      .upd_inc  (bp.upd_taken),
      .init_en  (!run),
      .init_idx (init_idx[LOCAL_IDX-1:0])
   );

   sat_counter_table #(.IDX(GHR_WIDTH), .CTR_WIDTH(CTR_WIDTH)) u_global (
      .clk      (clk),
      .rd_idx   (bp.pred_pc[GHR_WIDTH+1:2] ^ ghr),
      .rd_ctr   (glb_ctr),
      .upd_en   (run && bp.upd_valid),
      .upd_idx  (bp.upd_pc[GHR_WIDTH+1:2] ^ bp.upd_ghr),
      .upd_inc  (bp.upd_taken),
      .init_en  (!run),
      .init_idx (init_idx[GHR_WIDTH-1:0])
   );

   // Chooser only learns when the two components disagreed.
   sat_counter_table #(.IDX(CHOOSER_IDX), .CTR_WIDTH(CTR_WIDTH)) u_chooser (
      .clk      (clk),
      .rd_idx   (bp.pred_pc[CHOOSER_IDX+1:2]),
      .rd_ctr   (ch_ctr),
      .upd_en   (run && bp.upd_valid && (bp.upd_local_taken != bp.upd_global_taken)),
      .upd_idx  (bp.upd_pc[CHOOSER_IDX+1:2]),
      .upd_inc  (bp.upd_global_taken == bp.upd_taken),
      .init_en  (!run),
      .init_idx (init_idx[CHOOSER_IDX-1:0])
   );

   assign loc_msb = loc_ctr[CTR_WIDTH-1];
   assign glb_msb = glb_ctr[CTR_WIDTH-1];
   assign ch_msb  = ch_ctr[CTR_WIDTH-1];

   // Outputs forced quiet while the tables hold garbage.
   assign bp.ready             = run;
   assign bp.pred_local_taken  = run & loc_msb;
   assign bp.pred_global_taken = run & glb_msb;
   assign bp.pred_taken        = run & (ch_msb ? glb_msb : loc_msb);
   assign bp.pred_ghr          = run ? ghr : '0;

endmodule

// File: tb/tb_tournament_branch_predictor.sv
// Bench for the tournament predictor: directed scenarios plus a randomized
// run checked against an integer-array reference model (default config),
// and a directed 3-bit counter instance.
module tb_tournament_branch_predictor;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   tournament_branch_predictor_if #(.GHR_WIDTH(8)) bp ();
   tournament_branch_predictor_if #(.GHR_WIDTH(8)) b3 ();

   tournament_branch_predictor #(.CTR_WIDTH(2)) dut (.clk(clk), .rst(rst), .bp(bp));
   tournament_branch_predictor #(.CTR_WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bp(b3));

   // Reference model: counters as plain integers, 2-bit range 0..3.
   int m_loc [256];
   int m_glb [256];
   int m_ch  [256];
   int m_ghr;

   function automatic int sat(input int c, input bit up, input int maxc);
      if (up) return (c < maxc) ? c + 1 : c;
      return (c > 0) ? c - 1 : 0;
   endfunction

   function automatic int pc_ix(input logic [31:0] pc);
      return int'(pc >> 2) % 256;
   endfunction

   function automatic int m_pred_loc(input logic [31:0] pc);
      return (m_loc[pc_ix(pc)] >= 2) ? 1 : 0;
   endfunction

   function automatic int m_pred_glb(input logic [31:0] pc);
      return (m_glb[(pc_ix(pc) ^ m_ghr) % 256] >= 2) ? 1 : 0;
   endfunction

   function automatic int m_pred(input logic [31:0] pc);
      return (m_ch[pc_ix(pc)] >= 2) ? m_pred_glb(pc) : m_pred_loc(pc);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 256; i++) begin
         m_loc[i] = 1; m_glb[i] = 1; m_ch[i] = 1;
      end
      m_ghr = 0;
   endtask

   task automatic idle();
      bp.pred_valid = 0; bp.upd_valid = 0; bp.upd_mispredict = 0;
      bp.upd_taken = 0; bp.upd_local_taken = 0; bp.upd_global_taken = 0;
      bp.upd_pc = 32'h0; bp.upd_ghr = 8'h0;
      b3.pred_valid = 0; b3.upd_valid = 0; b3.upd_mispredict = 0;
      b3.upd_taken = 0; b3.upd_local_taken = 0; b3.upd_global_taken = 0;
      b3.upd_pc = 32'h0; b3.upd_ghr = 8'h0; b3.pred_pc = 32'h40;
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic [7:0] g, input bit t,
                          input bit l, input bit gl, input bit m);
      bp.upd_valid = 1; bp.upd_pc = pc; bp.upd_ghr = g; bp.upd_taken = t;
      bp.upd_local_taken = l; bp.upd_global_taken = gl; bp.upd_mispredict = m;
   endtask

   // One clock for the default DUT, advancing the model with the driven inputs.
   task automatic tick();
      int pred, li, gi;
      pred = m_pred(bp.pred_pc);
      @(posedge clk);
      if (bp.upd_valid) begin
         li = pc_ix(bp.upd_pc);
         gi = (li ^ int'(bp.upd_ghr)) % 256;
         m_loc[li] = sat(m_loc[li], bp.upd_taken, 3);
         m_glb[gi] = sat(m_glb[gi], bp.upd_taken, 3);
         if (bp.upd_local_taken != bp.upd_global_taken)
            m_ch[li] = sat(m_ch[li], bp.upd_global_taken == bp.upd_taken, 3);
      end
      if (bp.upd_valid && bp.upd_mispredict) m_ghr = (int'(bp.upd_ghr) * 2 + int'(bp.upd_taken)) % 256;
      else if (bp.pred_valid)                 m_ghr = (m_ghr * 2 + pred) % 256;
      #1;
   endtask

   task automatic wait_ready(output int cnt);
      bit bad_ghr;
      cnt = 0; bad_ghr = 0;
      while (bp.ready !== 1'b1 && cnt < 1000) begin
         @(posedge clk); #1; cnt++;
         if (bp.pred_ghr !== 8'h0 || bp.pred_taken !== 1'b0) bad_ghr = 1;
      end
      checks++;
      if (bad_ghr) begin
         errors++; $display("FAIL init_quiet: pred outputs nonzero during sweep, required 0");
      end
   endtask

   task automatic test_reset();
      int cnt;
      idle();
      rst = 0;
      bp.pred_pc = 32'h40;
      // Traffic during the sweep must be ignored.
      bp.pred_valid = 1;
      set_upd(32'h40, 8'h3, 1, 0, 1, 1);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bp.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bp.ready); end
      checks++;
      if (bp.pred_ghr !== 8'h0) begin errors++; $display("FAIL reset_ghr: got %h want 00", bp.pred_ghr); end
      rst = 1;
      wait_ready(cnt);
      checks++;
      if (cnt !== 256) begin errors++; $display("FAIL sweep_len: got %0d want 256", cnt); end
      checks++;
      if (b3.ready !== 1'b1) begin errors++; $display("FAIL sweep_len3: ready got %b want 1", b3.ready); end
      idle();
      bp.pred_pc = 32'h40;
      model_reset();
      #1;
      checks++;
      if ({bp.pred_taken, bp.pred_local_taken, bp.pred_global_taken} !== 3'b000 || bp.pred_ghr !== 8'h0) begin
         errors++;
         $display("FAIL post_init: t/l/g %b%b%b ghr %h want 000 ghr 00",
                  bp.pred_taken, bp.pred_local_taken, bp.pred_global_taken, bp.pred_ghr);
      end
   endtask

   task automatic test_local_counter();
      bit exp [7] = '{1, 1, 1, 1, 1, 1, 0};
      bit dir [7] = '{1, 1, 1, 1, 1, 0, 0};
      idle();
      bp.pred_pc = 32'h40;
      for (int i = 0; i < 7; i++) begin
         set_upd(32'h40, 8'h0, dir[i], 0, 0, 0);
         tick();
         bp.upd_valid = 0;
         #1;
         checks++;
         if (bp.pred_local_taken !== exp[i]) begin
            errors++; $display("FAIL local_step%0d: got %b want %b", i, bp.pred_local_taken, exp[i]);
         end
      end
   endtask

   task automatic test_ghr();
      logic [7:0] exp [4] = '{8'h00, 8'h01, 8'h03, 8'h07};
      idle();
      bp.pred_pc = 32'h40;
      set_upd(32'h40, 8'h0, 1, 0, 0, 0);
      tick();
      idle();
      bp.pred_pc = 32'h40;
      bp.pred_valid = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (bp.pred_ghr !== exp[i]) begin
            errors++; $display("FAIL ghr_shift%0d: got %h want %h", i, bp.pred_ghr, exp[i]);
         end
         if (i < 3) begin
            checks++;
            if (bp.pred_taken !== 1'b1) begin
               errors++; $display("FAIL ghr_pred%0d: got %b want 1", i, bp.pred_taken);
            end
            tick();
         end
      end
      set_upd(32'h80, 8'h05, 0, 0, 0, 1);
      tick();
      idle();
      #1;
      checks++;
      if (bp.pred_ghr !== 8'h0A) begin errors++; $display("FAIL ghr_repair: got %h want 0a", bp.pred_ghr); end
   endtask

   task automatic test_chooser();
      idle();
      set_upd(32'h100, 8'h0A, 1, 0, 0, 0); tick();
      set_upd(32'h100, 8'h33, 0, 0, 0, 0); tick();
      set_upd(32'h100, 8'h33, 0, 0, 0, 0); tick();
      idle();
      bp.pred_pc = 32'h100;
      #1;
      checks++;
      if ({bp.pred_taken, bp.pred_local_taken, bp.pred_global_taken} !== 3'b001) begin
         errors++; $display("FAIL chooser_local: t/l/g %b%b%b want 001",
                            bp.pred_taken, bp.pred_local_taken, bp.pred_global_taken);
      end
      set_upd(32'h100, 8'h55, 1, 0, 1, 0); tick();
      bp.upd_valid = 0; #1;
      checks++;
      if ({bp.pred_taken, bp.pred_local_taken, bp.pred_global_taken} !== 3'b101) begin
         errors++; $display("FAIL chooser_global: t/l/g %b%b%b want 101",
                            bp.pred_taken, bp.pred_local_taken, bp.pred_global_taken);
      end
      set_upd(32'h100, 8'h55, 0, 1, 1, 0); tick();
      bp.upd_valid = 0; #1;
      checks++;
      if (bp.pred_taken !== 1'b1) begin
         errors++; $display("FAIL chooser_hold: got %b want 1", bp.pred_taken);
      end
      checks++;
      if (bp.pred_ghr !== 8'h0A) begin errors++; $display("FAIL chooser_ghr: got %h want 0a", bp.pred_ghr); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         bp.pred_valid = 1'($urandom_range(0, 1));
         bp.pred_pc    = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2);
         bp.upd_valid  = ($urandom_range(0, 9) < 6);
         bp.upd_pc     = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2);
         bp.upd_ghr    = 8'($urandom_range(0, 15));
         bp.upd_taken        = 1'($urandom_range(0, 1));
         bp.upd_local_taken  = 1'($urandom_range(0, 1));
         bp.upd_global_taken = 1'($urandom_range(0, 1));
         bp.upd_mispredict   = ($urandom_range(0, 3) == 0);
         #1;
         checks++;
         if (bp.pred_taken !== 1'(m_pred(bp.pred_pc))) begin
            errors++; $display("FAIL rnd_taken n=%0d pc=%h: got %b want %0d", n, bp.pred_pc, bp.pred_taken, m_pred(bp.pred_pc));
         end
         checks++;
         if (bp.pred_local_taken !== 1'(m_pred_loc(bp.pred_pc))) begin
            errors++; $display("FAIL rnd_local n=%0d: got %b want %0d", n, bp.pred_local_taken, m_pred_loc(bp.pred_pc));
         end
         checks++;
         if (bp.pred_global_taken !== 1'(m_pred_glb(bp.pred_pc))) begin
            errors++; $display("FAIL rnd_global n=%0d: got %b want %0d", n, bp.pred_global_taken, m_pred_glb(bp.pred_pc));
         end
         checks++;
         if (bp.pred_ghr !== 8'(m_ghr)) begin
            errors++; $display("FAIL rnd_ghr n=%0d: got %h want %h", n, bp.pred_ghr, 8'(m_ghr));
         end
         tick();
      end
      idle();
   endtask

   task automatic test_reset_mid_init();
      int cnt;
      idle();
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      rst = 1;
      repeat (100) @(posedge clk);
      #1;
      rst = 0;
      #1;
      checks++;
      if (bp.ready !== 1'b0) begin errors++; $display("FAIL midinit_ready: got %b want 0", bp.ready); end
      rst = 1;
      wait_ready(cnt);
      checks++;
      if (cnt !== 256) begin errors++; $display("FAIL midinit_len: got %0d want 256", cnt); end
      model_reset();
      bp.pred_pc = 32'h40;
      #1;
      checks++;
      if (bp.pred_local_taken !== 1'b0) begin
         errors++; $display("FAIL midinit_reinit: local got %b want 0", bp.pred_local_taken);
      end
   endtask

   task automatic upd3(input bit t, input int times);
      b3.upd_valid = 1; b3.upd_pc = 32'h40; b3.upd_ghr = 8'h0; b3.upd_taken = t;
      repeat (times) @(posedge clk);
      #1;
      b3.upd_valid = 0;
      #1;
   endtask

   task automatic test_ctr3();
      bit exp [6] = '{0, 1, 1, 0, 0, 1};
      bit got [6];
      idle();
      #1;
      got[0] = b3.pred_local_taken;
      upd3(1, 1);  got[1] = b3.pred_local_taken;
      upd3(1, 10);
      upd3(0, 3);  got[2] = b3.pred_local_taken;
      upd3(0, 1);  got[3] = b3.pred_local_taken;
      upd3(0, 10);
      upd3(1, 3);  got[4] = b3.pred_local_taken;
      upd3(1, 1);  got[5] = b3.pred_local_taken;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp[i]) begin
            errors++; $display("FAIL ctr3_step%0d: got %b want %b", i, got[i], exp[i]);
         end
      end
      checks++;
      if (b3.pred_taken !== 1'b1) begin errors++; $display("FAIL ctr3_final: got %b want 1", b3.pred_taken); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_local_counter();
      test_ghr();
      test_chooser();
      test_random();
      test_reset_mid_init();
      test_ctr3();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
